pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-field EX/MEM-style latches between CPU pipeline stages: payload and control are opaque vectors, so one block serves IF/ID, ID/EX, EX/MEM and MEM/WB. Beyond a plain latch, it adds per-stage backpressure, a bubble-inserting flush, debug single-step gating and a sticky halt capture. It sits between two stages; the upstream stage drives the `i_*` side and the downstream stage consumes the `o_*` side.

---
 rtl/pipe_stage_skid.sv | 99 +++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Generic pipeline stage register: valid/ready handshake, 2-entry
//            skid buffer, flush, debug step gating and sticky halt capture.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W   = 197,
    parameter int CTRL_W   = 10,
    parameter int HALT_BIT = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_count,
    output logic              o_halted
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_halted;

    logic w_acc_in;
    logic w_acc_out;

    // Ready depends only on state and step, never on i_valid/i_ready,
    // so no combinational loop can form across chained stages.
    assign o_ready   = i_reset & i_step & ~r_skid_valid & ~r_halted;
    assign w_acc_in  = i_valid & o_ready;
    assign w_acc_out = r_main_valid & i_ready & i_step;

    assign o_valid  = r_main_valid;
    assign o_data   = r_main_data;
    assign o_ctrl   = r_main_ctrl & {CTRL_W{r_main_valid}};
    assign o_count  = {r_main_valid & r_skid_valid, r_main_valid ^ r_skid_valid};
    assign o_halted = r_halted;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_halted     <= 1'b0;
        end else begin
            // A halt beat leaving the stage is captured even under flush:
            // downstream has already taken it.
            if (w_acc_out && r_main_ctrl[HALT_BIT])
                r_halted <= 1'b1;

            if (i_flush) begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end else if (w_acc_in && w_acc_out) begin
                r_main_data <= i_data;
                r_main_ctrl <= i_ctrl;
            end else if (w_acc_in) begin
                if (r_main_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= i_data;
                    r_skid_ctrl  <= i_ctrl;
                end else begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= i_data;
                    r_main_ctrl  <= i_ctrl;
                end
            end else if (w_acc_out) begin
                if (r_skid_valid) begin
                    r_main_data  <= r_skid_data;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed self-checking bench for pipe_stage_skid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int c_data_w = 197;
    localparam int c_ctrl_w = 10;

    logic                i_clk;
    logic                i_reset;
    logic                i_step;
    logic                i_flush;
    logic                i_valid;
    logic                o_ready;
    logic [c_data_w-1:0] i_data;
    logic [c_ctrl_w-1:0] i_ctrl;
    logic                o_valid;
    logic                i_ready;
    logic [c_data_w-1:0] o_data;
    logic [c_ctrl_w-1:0] o_ctrl;
    logic [1:0]          o_count;
    logic                o_halted;

    int n_total;
    int n_pass;

    pipe_stage_skid #(
        .DATA_W   (c_data_w),
        .CTRL_W   (c_ctrl_w),
        .HALT_BIT (9)
    ) u_dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_step   (i_step),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_ctrl   (i_ctrl),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_ctrl   (o_ctrl),
        .o_count  (o_count),
        .o_halted (o_halted)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        i_reset = 1'b0;
        i_step  = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        i_ctrl  = '0;

        // Reset state
        #2;
        check("rst_valid",  o_valid,  0);
        check("rst_count",  o_count,  0);
        check("rst_halted", o_halted, 0);
        check("rst_ready",  o_ready,  0);
        check("rst_data",   o_data,   0);
        tick();
        i_reset = 1'b1;
        #1;
        check("rel_ready", o_ready, 1);

        // Streaming 1..8
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = k;
            i_ctrl  = k;
            tick();
            check("str_data",  o_data,  k);
            check("str_ctrl",  o_ctrl,  k);
            check("str_count", o_count, 1);
        end
        i_valid = 1'b0;
        tick();
        check("str_drain", o_count, 0);
        check("str_ctrl0", o_ctrl,  0);

        // Backpressure
        i_valid = 1'b1; i_data = 11; i_ctrl = 1;
        tick();
        check("bp_d11", o_data, 11);
        i_ready = 1'b0; i_data = 12;
        tick();
        check("bp_cnt2",  o_count, 2);
        check("bp_head",  o_data,  11);
        check("bp_ready", o_ready, 0);
        i_data = 13;
        tick();
        tick();
        check("bp_hold_cnt",  o_count, 2);
        check("bp_hold_head", o_data,  11);
        i_ready = 1'b1;
        tick();
        check("bp_d12",   o_data,  12);
        check("bp_cnt1",  o_count, 1);
        check("bp_rdy1",  o_ready, 1);
        tick();
        check("bp_d13",   o_data,  13);
        i_valid = 1'b0;
        tick();
        check("bp_empty", o_count, 0);

        // Flush with both entries full and a beat offered
        i_ready = 1'b0; i_valid = 1'b1; i_data = 21; i_ctrl = 3;
        tick();
        i_data = 22;
        tick();
        check("fl_cnt2", o_count, 2);
        i_data = 23; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        check("fl_valid", o_valid, 0);
        check("fl_ctrl",  o_ctrl,  0);
        check("fl_count", o_count, 0);
        tick();
        check("fl_after", o_count, 0);
        // Flush discards a beat accepted in the same cycle
        i_valid = 1'b1; i_data = 24; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        check("fl_accdrop", o_count, 0);

        // Step gating
        i_ready = 1'b0; i_valid = 1'b1; i_data = 31; i_ctrl = 5;
        tick();
        i_step = 1'b0; i_data = 32; i_ctrl = 6; i_ready = 1'b1;
        #1;
        check("st_ready0", o_ready, 0);
        for (int k = 0; k < 5; k++) tick();
        check("st_frz_data",  o_data,  31);
        check("st_frz_count", o_count, 1);
        check("st_frz_valid", o_valid, 1);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("st_adv_data",  o_data,  32);
        check("st_adv_count", o_count, 1);
        tick();
        check("st_hold_data", o_data, 32);
        i_step = 1'b1; i_valid = 1'b0;
        tick();
        check("st_drain", o_count, 0);

        // Halt
        i_valid = 1'b1; i_data = 41; i_ctrl = 10'h200; i_ready = 1'b0;
        tick();
        check("h_ctrl", o_ctrl, 10'h200);
        i_valid = 1'b0; i_ready = 1'b1;
        tick();
        check("h_set",   o_halted, 1);
        check("h_ready", o_ready,  0);
        i_valid = 1'b1; i_data = 42; i_ctrl = 0;
        tick();
        i_data = 43;
        tick();
        check("h_noacc", o_count, 0);
        check("h_novld", o_valid, 0);
        i_valid = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("h_flush", o_halted, 1);
        #2;
        i_reset = 1'b0;
        #1;
        check("h_rst", o_halted, 0);
        tick();
        i_reset = 1'b1;

        // Asynchronous reset with two entries held
        i_ready = 1'b0; i_valid = 1'b1; i_data = 51; i_ctrl = 7;
        tick();
        i_data = 52;
        tick();
        i_valid = 1'b0;
        check("ar_cnt2", o_count, 2);
        #2;
        i_reset = 1'b0;
        #1;
        check("ar_count", o_count, 0);
        check("ar_valid", o_valid, 0);
        check("ar_data",  o_data,  0);
        check("ar_ctrl",  o_ctrl,  0);
        check("ar_ready", o_ready, 0);
        tick();
        i_reset = 1'b1;
        tick();
        check("ar_rel", o_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
